// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state type and requester limit for the UART TX path
package uart_pkg;
  localparam int UART_ARB_MAX_REQ = 8;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester handshakes and TX FIFO write port around the arbiter
interface uart_tx_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0]              tx_data;
  logic                               tx_wr_en;
  logic                               tx_full;
  modport master (output req_valid, req_data, req_last, tx_full, input req_ready, tx_data, tx_wr_en);
  modport slave  (input req_valid, req_data, req_last, tx_full, output req_ready, tx_data, tx_wr_en);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, searching upward from last_owner+1 with wrap
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last_owner,
  output logic [LW-1:0]      winner,
  output logic               any_req
);
  logic [LW-1:0] idx;
  // walking from farthest to nearest leaves the nearest requester as winner
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = LW'((int'(last_owner) + i) % NUM_REQ);
      winner = req[idx] ? idx : winner;
    end
    any_req = |req;
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-locked round-robin arbiter feeding a UART TX FIFO write port.
// Define UART_ARB_TIMEOUT_EN to revoke grants from owners idle for TIMEOUT_CYCLES.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int LW             = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.slave  bus,
  input  logic          arb_abort,
  output logic [LW-1:0] grant_id,
  output logic          busy,
  output logic          timeout_err
);
  arb_state_t            state_q, state_d;
  logic [LW-1:0]         grant_q, grant_d, last_q, last_d, win;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  any_req, locked, xfer, rel, tmo;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req_valid), .last_owner(last_q), .winner(win), .any_req(any_req)
  );

  // an abort suppresses the handshake as well, so nothing is accepted without a write
  always_comb begin
    locked = state_q == LOCKED;
    bus.req_ready = '0;
    bus.req_ready[grant_q] = locked & ~bus.tx_full & ~arb_abort;
    xfer = locked & bus.req_valid[grant_q] & ~bus.tx_full & ~arb_abort;
    rel = arb_abort | tmo | (xfer & bus.req_last[grant_q]);
    state_d = locked ? (rel ? IDLE : LOCKED) : (any_req ? LOCKED : IDLE);
    grant_d = (!locked && any_req) ? win : grant_q;
    last_d = (locked && rel) ? grant_q : last_q;
    bus.tx_wr_en = xfer;
    bus.tx_data = xfer ? bus.req_data[grant_q] : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= LW'(NUM_REQ - 1);
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      tx_data_q <= bus.tx_data;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;
  // FIFO backpressure is not the owner's fault, so only owner silence counts
  always_comb begin
    stall = (state_q == LOCKED) & ~bus.req_valid[grant_q] & ~bus.tx_full;
    tmo = stall & ~arb_abort & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    cnt_d = (state_q == IDLE || xfer) ? '0 : stall ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign tmo = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  assign grant_id = grant_q;
  assign busy = state_q == LOCKED;
  assign timeout_err = tmo;
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the UART TX FIFO write port; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte width, equal to the UART DATA_WIDTH.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: stall limit for a granted requester; used only when UART_ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ: per-requester byte valid.
REQ-007 req_data  input  NUM_REQ x DATA_WIDTH: per-requester byte.
REQ-008 req_last  input  NUM_REQ: marks the final byte of a packet.
REQ-009 req_ready  output  NUM_REQ: per-requester byte accepted this cycle when ANDed with req_valid.
REQ-010 tx_data  output  DATA_WIDTH: byte to the TX FIFO.
REQ-011 tx_wr_en  output  1: TX FIFO write strobe.
REQ-012 tx_full  input  1: TX FIFO full.
REQ-013 arb_abort  input  1: synchronous abort; drops the current grant.
REQ-014 grant_id  output  $clog2(NUM_REQ): index of the current owner; holds the last owner while idle.
REQ-015 busy  output  1: high while a packet is locked.
REQ-016 timeout_err  output  1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 FSM states: IDLE and LOCKED.
REQ-018 IDLE, any req_valid high: registers the winner into grant_id and enters LOCKED next cycle (1-cycle arbitration latency; no byte transfers in IDLE).
REQ-019 Winner selection: round-robin, searching from (last_owner+1) mod NUM_REQ upward with wrap; after reset last_owner = NUM_REQ-1, so requester 0 has first priority.
REQ-020 LOCKED: req_ready[grant_id] = ~tx_full; all other req_ready bits are 0.
REQ-021 Transfer: when req_valid[g] & req_ready[g]: tx_wr_en=1, tx_data=req_data[g], same cycle (combinational path); otherwise tx_wr_en=0 and tx_data holds its last value.
REQ-022 Transfer with req_last[g]=1: return to IDLE next cycle and set last_owner=g; minimum packet occupancy is 2 cycles (grant plus one byte).
REQ-023 tx_full high: no transfer, grant is held, and the stall does not count toward timeout.
REQ-024 tx_wr_en shall never assert while tx_full=1.
REQ-025 arb_abort high in LOCKED: tx_wr_en forced 0 that cycle, go to IDLE, last_owner=g, no timeout_err; arb_abort high in IDLE is ignored.
REQ-026 req_valid deasserting mid-packet does not release the grant; only last, abort or timeout release it.
REQ-027 busy = (state==LOCKED).

Reset
REQ-028 On rst_n low: state=IDLE, last_owner=NUM_REQ-1, grant_id=0, tx_data=0, tx_wr_en=0, req_ready=0, busy=0, timeout_err=0, stall counter=0.
REQ-029 Reset mid-packet discards the partial packet with no further writes; the FIFO contents are the system's responsibility.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: a counter clears on grant and on each transfer, and increments each LOCKED cycle with req_valid[g]=0 and tx_full=0.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1 and increments: go to IDLE, last_owner=g, timeout_err pulses for 1 cycle.
REQ-032 Macro undefined: no counter is built, timeout_err is tied 0, and the grant is held indefinitely.

Structure
REQ-033 The shared package uart_pkg holds the arb_state_t enum (IDLE, LOCKED) and the UART_ARB_MAX_REQ=8 constant.
REQ-034 Sub-module uart_rr_pick: combinational round-robin picker with inputs req vector and last_owner, outputs winner index and any_req.

Verification
REQ-035 Single requester: r0 sends 3-byte packet 0xA1,0xA2,0xA3 (last on 0xA3) -> tx_wr_en high 3 cycles, bytes in order, busy low 1 cycle after 0xA3.
REQ-036 Round-robin: r0..r3 all hold 1-byte packets continuously -> grant order 0,1,2,3,0, with each byte written exactly once.
REQ-037 Lock: r2 sends 4-byte packet while r1 requests -> no r1 byte appears until r2's last byte; then r3 is skipped if idle and r1 wins.
REQ-038 Backpressure: tx_full=1 for 5 cycles mid-packet -> tx_wr_en=0 and req_ready=0 during those cycles, no byte lost or duplicated, no timeout.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=16): r0 granted, valid dropped after 1 byte -> timeout_err pulse after 16 idle cycles, then r1 granted.
REQ-040 Abort and reset: arb_abort during byte 2 of 4 -> no write that cycle, IDLE next cycle; rst_n low mid-packet -> all outputs at reset values immediately.
